// File: rtl/arbitro_vc_pkg.sv
// Shared definitions for the virtual-channel arbiter: controller state encoding
// and the position of the class field inside a datapath word.
package arbitro_vc_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } ctrl_state_e;

  localparam int NUM_VC = 4;

  // The destination class occupies the top CLASS_W bits of every word.
  localparam int CLASS_W = 2;

endpackage

// File: rtl/arbitro_vc_round_robin_4.sv
// Combinational 4-way rotating-priority selector: the search starts one past
// the previous winner and the first eligible requester takes the grant.
module round_robin_4 (
  input  logic [3:0] eligible,
  input  logic [1:0] last,
  output logic [3:0] grant,
  output logic [1:0] grant_idx
);

  logic [1:0] cand;
  logic       found;

  // NOTE: every output and temporary gets a default before the loop so no
  // path through this block leaves a value unassigned (no inferred latch).
  always_comb begin
    grant     = '0;
    grant_idx = last;
    cand      = last;
    found     = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_vc.sv
// Round-robin drain of four VC source FIFOs into four destination FIFOs,
// gated by controller state and per-destination pause hysteresis.
module arbitro_vc #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_VC     = 4,
  parameter int CNT_W      = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   state,
  input  logic [CNT_W-1:0]             Umbral_superior,
  input  logic [CNT_W-1:0]             Umbral_inferior,
  input  logic [NUM_VC-1:0]            src_empty,
  input  logic [NUM_VC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_VC-1:0]            src_pop,
  input  logic [NUM_VC*CNT_W-1:0]      dst_count,
  output logic [NUM_VC-1:0]            dst_push,
  output logic [DATA_WIDTH-1:0]        dst_data,
  output logic                         pausa,
  output logic                         idle
);

  import arbitro_vc_pkg::*;

  logic                  active;
  logic [1:0]            last;
  logic [NUM_VC-1:0]     paused;
  logic [NUM_VC-1:0]     paused_nxt;
  logic [NUM_VC-1:0]     eligible;
  logic [NUM_VC-1:0]     grant;
  logic [1:0]            grant_idx;
  logic                  any_grant;
  logic [DATA_WIDTH-1:0] granted_word;
  logic [CLASS_W-1:0]    granted_class;
  logic [NUM_VC-1:0]     push_nxt;
  logic [CLASS_W-1:0]    head_class [NUM_VC];

  assign active = (state == ST_ACTIVE);

  // Holding reset low also masks eligibility, so a grant in the reset cycle
  // never pops a word that the cleared push register would then drop.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      head_class[i] = src_data[i*DATA_WIDTH + DATA_WIDTH - CLASS_W +: CLASS_W];
      eligible[i]   = reset && active && !src_empty[i] && !paused[head_class[i]];
    end
  end

  round_robin_4 u_rr (
    .eligible  (eligible),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign src_pop       = grant;
  assign any_grant     = |grant;
  assign granted_word  = src_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign granted_class = granted_word[DATA_WIDTH-1 -: CLASS_W];

  always_comb begin
    push_nxt = '0;
    for (int d = 0; d < NUM_VC; d++)
      push_nxt[d] = any_grant && (granted_class == CLASS_W'(d));
  end

  // Set wins over clear, so inverted thresholds still pause at or above superior.
  always_comb begin
    paused_nxt = paused;
    if (!active) begin
      paused_nxt = '0;
    end else begin
      for (int d = 0; d < NUM_VC; d++) begin
        if (dst_count[d*CNT_W +: CNT_W] >= Umbral_superior)
          paused_nxt[d] = 1'b1;
        else if (dst_count[d*CNT_W +: CNT_W] <= Umbral_inferior)
          paused_nxt[d] = 1'b0;
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last     <= 2'd3;
      paused   <= '0;
      dst_push <= '0;
      dst_data <= '0;
      pausa    <= 1'b0;
      idle     <= 1'b1;
    end else begin
      paused   <= paused_nxt;
      pausa    <= |paused_nxt;
      dst_push <= push_nxt;
      idle     <= (&src_empty) && !any_grant;
      if (any_grant) begin
        last     <= grant_idx;
        dst_data <= granted_word;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_vc.sv
// Self-checking bench for arbitro_vc: directed vector table, hand-written
// state-gating sequence and randomized traffic against a behavioural model.
module tb_arbitro_vc;

  localparam int DW = 6;
  localparam int NV = 4;
  localparam int CW = 3;
  localparam logic [3:0] ACT  = 4'b1000;
  localparam logic [3:0] IDL  = 4'b0100;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       state;
  logic [CW-1:0]    Umbral_superior;
  logic [CW-1:0]    Umbral_inferior;
  logic [NV-1:0]    src_empty;
  logic [NV*DW-1:0] src_data;
  logic [NV-1:0]    src_pop;
  logic [NV*CW-1:0] dst_count;
  logic [NV-1:0]    dst_push;
  logic [DW-1:0]    dst_data;
  logic             pausa;
  logic             idle;

  always #5 clk = ~clk;

  arbitro_vc #(.DATA_WIDTH(DW), .NUM_VC(NV), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .state           (state),
    .Umbral_superior (Umbral_superior),
    .Umbral_inferior (Umbral_inferior),
    .src_empty       (src_empty),
    .src_data        (src_data),
    .src_pop         (src_pop),
    .dst_count       (dst_count),
    .dst_push        (dst_push),
    .dst_data        (dst_data),
    .pausa           (pausa),
    .idle            (idle)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int         m_last = 3;
  bit [3:0]   m_paused = '0;
  logic [3:0] m_push = '0;
  logic [5:0] m_data = '0;
  logic       m_pausa = 1'b0;
  logic       m_idle = 1'b1;
  logic [3:0] obs_pop;
  logic [3:0] obs_push;

  // One clock cycle: drive, check the combinational pop mid-cycle, then check
  // the registered outputs just after the rising edge.
  task automatic cycle(input logic rst_v, input logic [3:0] st,
                       input logic [2:0] sup, input logic [2:0] inf,
                       input logic [3:0] empty, input logic [23:0] data,
                       input logic [11:0] cnt);
    int win;
    int s;
    int c;
    logic [5:0] w;
    reset           = rst_v;
    state           = st;
    Umbral_superior = sup;
    Umbral_inferior = inf;
    src_empty       = empty;
    src_data        = data;
    dst_count       = cnt;
    #3;
    win = -1;
    if (rst_v && st == ACT) begin
      for (int k = 1; k <= 4; k++) begin
        s = (m_last + k) % 4;
        w = data[s*6 +: 6];
        if (win < 0 && !empty[s] && !m_paused[w[5:4]]) win = s;
      end
    end
    obs_pop  = src_pop;
    obs_push = dst_push;
    check("src_pop", src_pop, (win < 0) ? 32'd0 : (32'd1 << win));
    @(posedge clk);
    #1;
    if (!rst_v) begin
      m_last = 3; m_paused = '0; m_push = '0; m_data = '0; m_pausa = 1'b0; m_idle = 1'b1;
    end else begin
      if (win >= 0) begin
        w      = data[win*6 +: 6];
        m_last = win;
        m_push = 4'(1 << w[5:4]);
        m_data = w;
      end else begin
        m_push = '0;
      end
      for (int d = 0; d < 4; d++) begin
        c = int'(cnt[d*3 +: 3]);
        if (st != ACT)          m_paused[d] = 1'b0;
        else if (c >= int'(sup)) m_paused[d] = 1'b1;
        else if (c <= int'(inf)) m_paused[d] = 1'b0;
      end
      m_pausa = |m_paused;
      m_idle  = &empty;
    end
    check("dst_push", dst_push, m_push);
    check("dst_data", dst_data, m_data);
    check("pausa", pausa, m_pausa);
    check("idle", idle, m_idle);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  st;
    logic [2:0]  sup;
    logic [2:0]  inf;
    logic [3:0]  empty;
    logic [23:0] data;
    logic [11:0] cnt;
    logic [3:0]  exp_pop;
    logic [3:0]  exp_push;
    logic        exp_pausa;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] sup, logic [2:0] inf, logic [3:0] empty,
                              logic [23:0] data, logic [11:0] cnt,
                              logic [3:0] ep, logic [3:0] eh, logic ea);
    vec_t v;
    v.rst = 1'b1; v.st = ACT; v.sup = sup; v.inf = inf; v.empty = empty;
    v.data = data; v.cnt = cnt; v.exp_pop = ep; v.exp_push = eh; v.exp_pausa = ea;
    return v;
  endfunction

  initial begin
    logic [23:0] fair_d;
    logic [23:0] part_d;
    fair_d = {6'h34, 6'h23, 6'h12, 6'h01};  // class of source i is i
    part_d = {6'h00, 6'h00, 6'h36, 6'h25};  // src0 -> class 2, src1 -> class 3

    // Fairness: rotation 0,1,2,3,0 with push mirroring the pop
    tbl.push_back(mk(3'd6, 3'd2, 4'b0000, fair_d, 12'd0, 4'b0001, 4'b0001, 1'b0));
    tbl.push_back(mk(3'd6, 3'd2, 4'b0000, fair_d, 12'd0, 4'b0010, 4'b0010, 1'b0));
    tbl.push_back(mk(3'd6, 3'd2, 4'b0000, fair_d, 12'd0, 4'b0100, 4'b0100, 1'b0));
    tbl.push_back(mk(3'd6, 3'd2, 4'b0000, fair_d, 12'd0, 4'b1000, 4'b1000, 1'b0));
    tbl.push_back(mk(3'd6, 3'd2, 4'b0000, fair_d, 12'd0, 4'b0001, 4'b0001, 1'b0));
    // Hysteresis on destination 1: count 4,5,4,3,2,2
    tbl.push_back(mk(3'd5, 3'd2, 4'b1101, fair_d, {3'd0, 3'd0, 3'd4, 3'd0}, 4'b0010, 4'b0010, 1'b0));
    tbl.push_back(mk(3'd5, 3'd2, 4'b1101, fair_d, {3'd0, 3'd0, 3'd5, 3'd0}, 4'b0010, 4'b0010, 1'b1));
    tbl.push_back(mk(3'd5, 3'd2, 4'b1101, fair_d, {3'd0, 3'd0, 3'd4, 3'd0}, 4'b0000, 4'b0000, 1'b1));
    tbl.push_back(mk(3'd5, 3'd2, 4'b1101, fair_d, {3'd0, 3'd0, 3'd3, 3'd0}, 4'b0000, 4'b0000, 1'b1));
    tbl.push_back(mk(3'd5, 3'd2, 4'b1101, fair_d, {3'd0, 3'd0, 3'd2, 3'd0}, 4'b0000, 4'b0000, 1'b0));
    tbl.push_back(mk(3'd5, 3'd2, 4'b1101, fair_d, {3'd0, 3'd0, 3'd2, 3'd0}, 4'b0010, 4'b0010, 1'b0));
    // Partial blocking: pause destination 2, then only source 1 proceeds
    tbl.push_back(mk(3'd5, 3'd2, 4'b1111, part_d, {3'd0, 3'd5, 3'd0, 3'd0}, 4'b0000, 4'b0000, 1'b1));
    tbl.push_back(mk(3'd5, 3'd2, 4'b1100, part_d, {3'd0, 3'd5, 3'd0, 3'd0}, 4'b0010, 4'b1000, 1'b1));
    tbl.push_back(mk(3'd5, 3'd2, 4'b1100, part_d, {3'd0, 3'd5, 3'd0, 3'd0}, 4'b0010, 4'b1000, 1'b1));
    tbl.push_back(mk(3'd5, 3'd2, 4'b1100, part_d, {3'd0, 3'd5, 3'd0, 3'd0}, 4'b0010, 4'b1000, 1'b1));
    // Misconfigured thresholds: superior 3, inferior 5
    tbl.push_back(mk(3'd3, 3'd5, 4'b1111, fair_d, {3'd0, 3'd0, 3'd0, 3'd4}, 4'b0000, 4'b0000, 1'b1));
    tbl.push_back(mk(3'd3, 3'd5, 4'b1111, fair_d, {3'd0, 3'd0, 3'd0, 3'd2}, 4'b0000, 4'b0000, 1'b0));

    @(posedge clk);
    #1;

    // Reset held for two cycles with traffic pending
    for (int r = 0; r < 2; r++) begin
      cycle(1'b0, ACT, 3'd6, 3'd2, 4'b0000, fair_d, 12'd0);
      check("rst_pop", obs_pop, 4'b0000);
      check("rst_push", dst_push, 4'b0000);
      check("rst_data", dst_data, 6'd0);
      check("rst_idle", idle, 1'b1);
      check("rst_pausa", pausa, 1'b0);
    end

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].st, tbl[i].sup, tbl[i].inf, tbl[i].empty,
            tbl[i].data, tbl[i].cnt);
      check($sformatf("tbl%0d_pop", i), obs_pop, tbl[i].exp_pop);
      check($sformatf("tbl%0d_push", i), dst_push, tbl[i].exp_push);
      check($sformatf("tbl%0d_pausa", i), pausa, tbl[i].exp_pausa);
    end

    // State gating: grant in ACTIVE, then drop to IDLE in the next grant cycle
    cycle(1'b1, ACT, 3'd5, 3'd2, 4'b0000, fair_d, {3'd7, 3'd0, 3'd0, 3'd0});
    check("gate_a_pop", obs_pop, 4'b0100);
    check("gate_a_push", dst_push, 4'b0100);
    check("gate_a_pausa", pausa, 1'b1);
    cycle(1'b1, IDL, 3'd5, 3'd2, 4'b0000, fair_d, {3'd7, 3'd0, 3'd0, 3'd0});
    check("gate_b_pop", obs_pop, 4'b0000);
    check("gate_b_prev_push", obs_push, 4'b0100);
    check("gate_b_push", dst_push, 4'b0000);
    check("gate_b_pausa", pausa, 1'b0);
    cycle(1'b1, ACT, 3'd5, 3'd2, 4'b0000, fair_d, 12'd0);
    check("gate_c_pop", obs_pop, 4'b1000);

    // Randomized traffic, occasional reset and non-ACTIVE states
    for (int n = 0; n < 600; n++) begin
      logic       rv;
      logic [3:0] st;
      rv = ($urandom_range(0, 40) != 0);
      case ($urandom_range(0, 9))
        0:       st = 4'b0001;
        1:       st = 4'b0010;
        2:       st = 4'b0100;
        default: st = ACT;
      endcase
      cycle(rv, st, 3'($urandom), 3'($urandom), 4'($urandom),
            24'($urandom), 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_vc.md
# arbitro_vc

Round-robin scheduler that drains four virtual-channel source FIFOs into four destination FIFOs in the PCIe transaction-layer datapath. It pops at most one word per cycle and routes it by its class bits. Routing is gated by the controller state (only in ACTIVE) and by per-destination pause flags with hysteresis set from the controller's configured thresholds `Umbral_superior`/`Umbral_inferior`.

## Interface
- `DATA_WIDTH`, 6: word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the destination class.
- `NUM_VC`, 4: number of sources and destinations (fixed at 4; 2-bit class).
- `CNT_W`, 3: width of thresholds and destination fill counts.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `state` in 4: controller state, one-hot (RESET 0001, INIT 0010, IDLE 0100, ACTIVE 1000).
- `Umbral_superior` in CNT_W: pause-set threshold.
- `Umbral_inferior` in CNT_W: pause-clear threshold.
- `src_empty` in NUM_VC: source FIFO empty flags.
- `src_data` in NUM_VC*DATA_WIDTH: show-ahead head words; source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `src_pop` out NUM_VC: one-hot pop, combinational, same cycle as grant.
- `dst_count` in NUM_VC*CNT_W: destination FIFO fill levels.
- `dst_push` out NUM_VC: one-hot push, registered.
- `dst_data` out DATA_WIDTH: pushed word, registered.
- `pausa` out 1: registered OR of the per-destination pause flags.
- `idle` out 1: registered; 1 when all sources are empty and no push is issued this cycle.

## Operation
- **Eligibility:** source i is eligible when `src_empty[i]`=0, `state`=ACTIVE, and the class of its head word d has `paused[d]`=0 (registered flag).
- **Arbitration:** round-robin.
  - Search starts at `last+1` mod 4; the first eligible source wins.
  - `src_pop[win]`=1 in the same cycle.
  - `last` updates to `win` at the edge.
  - With no eligible source, `src_pop`=0 and `last` holds.
- **Routing:** at the edge after a grant, `dst_push[d]`=1 and `dst_data` = the granted word, with d = class bits. Otherwise `dst_push`=0 and `dst_data` holds its last value.
- **Pause hysteresis per destination d, evaluated every cycle:**
  - `dst_count[d] >= Umbral_superior` → set.
  - else `dst_count[d] <= Umbral_inferior` → clear.
  - else hold.
  - Set has priority, so with misconfigured thresholds (inferior ≥ superior) the flag is set whenever count ≥ superior.
- **Non-ACTIVE state (RESET, INIT, IDLE):** no pops; `dst_push`=0 from the next edge; pause flags are cleared; `last` is retained.
- **Head-of-line blocking:** a paused destination blocks only sources whose head targets it. Other sources continue in round-robin order.
- **Comparisons:** unsigned, CNT_W bits; no wrap.

## Timing
- **Reset values** (`reset`=0 at an edge): `dst_push`=0, `dst_data`=0, `pausa`=0, `idle`=1, all pause flags=0, `last`=3 so source 0 wins first. `src_pop`=0 combinationally while `reset`=0.
- **Reset mid-operation:** any grant in the reset cycle is suppressed (`src_pop`=0). No word is lost or duplicated.
- **Latency:** pop in cycle N, push at edge N+1. Throughput is 1 word per cycle.
- **Pause lag:** a count crossing in cycle N is flagged at edge N+1 and affects grants from cycle N+1. Up to 2 further words can reach the destination after the count first equals `Umbral_superior`. Destination depth must be ≥ `Umbral_superior`+2.
- **State leaving ACTIVE in cycle N:** no pop in cycle N; a push from a cycle N-1 grant still completes at edge N.

## Structure
- **Shared package:** state encodings RESET/INIT/IDLE/ACTIVE (common with the controller), `NUM_VC`, class-bit position constants.
- **Sub-module `round_robin_4`:** combinational 4-way rotating-priority selector. Inputs are the eligible vector and `last`; output is the one-hot grant plus its index. The pointer register stays in `arbitro_vc`.

## Test plan
- **Reset:** `reset`=0 for 2 cycles with all sources non-empty and `state`=ACTIVE → `src_pop`=0, `dst_push`=0, `dst_data`=0, `idle`=1, `pausa`=0.
- **Fairness:** `state`=ACTIVE, all four sources non-empty, class = source index, counts 0, thresholds 6/2 → `src_pop` sequence 0001, 0010, 0100, 1000, 0001, and `dst_push` mirrors it one cycle later.
- **Hysteresis:** thresholds superior=5, inferior=2; drive `dst_count[1]` 4→5→4→3→2 → `pausa` rises one cycle after count=5, stays high at 4 and 3, and falls one cycle after count=2. Class-1 sources get no grant while paused.
- **Partial blocking:** destination 2 paused; source 0 head has class 2 and source 1 head has class 3 → only source 1 is granted, repeatedly, and source 0 waits.
- **State gating:** drop `state` from ACTIVE to IDLE in the cycle a grant would occur → `src_pop`=0 that cycle, the previous cycle's push still completes, and all pause flags clear at the next edge.
- **Misconfiguration:** superior=3, inferior=5, count=4 → flag set; count=2 → flag cleared.
